// File: rtl/cache_line_mover_pkg.sv
// Shared definitions for the cache line mover slice.
// Contents: line/word geometry constants, the mover FSM state type and a
// helper that maps a word index within a line to its bit offset.
package cache_pkg;

  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_W         = 16;
  localparam int WORD_IDX_W     = 3;

  typedef enum logic [3:0] {
    IDLE,
    RD,
    CHK,
    WB_CMD,
    WB_DATA,
    FILL_CMD,
    FILL_DATA,
    COMMIT,
    DONE
  } mover_state_t;

  // Bit offset of word idx inside a line (word k = bits 16k+15:16k).
  function automatic int unsigned word_lsb(input int unsigned idx);
    return idx * WORD_W;
  endfunction

endpackage

// File: rtl/cache_line_mover_if.sv
// Burst interface between the line mover and the 16-bit memory controller.
// Signals: command (valid/ready/write/addr), writeback word stream
// (wdata/valid/ready) and fill word stream (rdata/valid, no backpressure).
// Modports: master = line mover side, slave = memory controller side.
interface cache_line_mover_if #(
  parameter int LINE_ADDR_W = 22
);

  logic                        mem_cmd_valid;
  logic                        mem_cmd_ready;
  logic                        mem_cmd_write;
  logic [LINE_ADDR_W-1:0]      mem_cmd_addr;
  logic [cache_pkg::WORD_W-1:0] mem_wdata;
  logic                        mem_wdata_valid;
  logic                        mem_wdata_ready;
  logic [cache_pkg::WORD_W-1:0] mem_rdata;
  logic                        mem_rdata_valid;

  modport master (
    output mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
    output mem_wdata, mem_wdata_valid,
    input  mem_cmd_ready, mem_wdata_ready,
    input  mem_rdata, mem_rdata_valid
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
    input  mem_wdata, mem_wdata_valid,
    output mem_cmd_ready, mem_wdata_ready,
    output mem_rdata, mem_rdata_valid
  );

endinterface

// File: rtl/cache_line_mover_line_buffer.sv
// cache_line_buffer: one 128-bit line held as eight 16-bit word registers.
// Ports: clk, rst_n (synchronous, active-low), load_en/load_line (full-line
// load, wins over a word write), wr_en/wr_idx/wr_data (single word write),
// rd_idx/rd_data (indexed word read mux), line (whole buffer contents).
module cache_line_buffer
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [LINE_W-1:0]     load_line,
  input  logic                  wr_en,
  input  logic [WORD_IDX_W-1:0] wr_idx,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic [WORD_IDX_W-1:0] rd_idx,
  output logic [WORD_W-1:0]     rd_data,
  output logic [LINE_W-1:0]     line
);

  for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
    logic [WORD_W-1:0] word_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        word_reg <= '0;
      end else if (load_en) begin
        word_reg <= load_line[word_lsb(gi) +: WORD_W];
      end else if (wr_en && (wr_idx == WORD_IDX_W'(gi))) begin
        word_reg <= wr_data;
      end
    end

    assign line[word_lsb(gi) +: WORD_W] = word_reg;
  end

  assign rd_data = line[word_lsb(32'(rd_idx)) +: WORD_W];

endmodule

// File: rtl/cache_line_mover.sv
// cache_line_mover: miss-service engine between the cache control FSM, the
// cache data array and the 16-bit memory controller. Reads the victim line,
// writes it back as an 8-word burst when dirty, fetches the replacement line
// as an 8-word burst and commits it with a single full-line array write.
// Ports: main_clk, main_rst_n (synchronous, active-low); req_* request
// handshake; done pulse; target_segment/target_way, do_full_write,
// raw_in_full_data, raw_out_full_data, out_dirty to/from the data array;
// mem (cache_line_mover_if.master) to the memory controller.
// Optional: define CACHE_LINE_MOVER_FILL_FORWARD_EN to add fwd_valid,
// fwd_index and fwd_word, which echo each fill word one cycle after it lands.
module cache_line_mover
  import cache_pkg::*;
#(
  parameter int LINE_ADDR_W = 22,
  parameter int SEG_W       = 9,
  parameter int WAY_W       = 2
) (
  input  logic                   main_clk,
  input  logic                   main_rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SEG_W-1:0]       req_segment,
  input  logic [WAY_W-1:0]       req_way,
  input  logic [LINE_ADDR_W-1:0] req_evict_addr,
  input  logic [LINE_ADDR_W-1:0] req_fill_addr,
  output logic                   done,
  output logic [SEG_W-1:0]       target_segment,
  output logic [WAY_W-1:0]       target_way,
  output logic                   do_full_write,
  output logic [LINE_W-1:0]      raw_in_full_data,
  input  logic [LINE_W-1:0]      raw_out_full_data,
  input  logic                   out_dirty,
  cache_line_mover_if.master     mem
`ifdef CACHE_LINE_MOVER_FILL_FORWARD_EN
  ,
  output logic                   fwd_valid,
  output logic [WORD_IDX_W-1:0]  fwd_index,
  output logic [WORD_W-1:0]      fwd_word
`endif
);

  mover_state_t           state_reg, state_next;
  logic [WORD_IDX_W-1:0]  cnt_reg, cnt_next;
  logic [SEG_W-1:0]       seg_reg;
  logic [WAY_W-1:0]       way_reg;
  logic [LINE_ADDR_W-1:0] evict_reg, fill_reg;
  logic                   buf_load, buf_wr;
  logic [WORD_W-1:0]      buf_rd_data;

  always_ff @(posedge main_clk) begin
    if (!main_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      seg_reg   <= '0;
      way_reg   <= '0;
      evict_reg <= '0;
      fill_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && req_valid) begin
        seg_reg   <= req_segment;
        way_reg   <= req_way;
        evict_reg <= req_evict_addr;
        fill_reg  <= req_fill_addr;
      end
    end
  end

  // The dirty flag is consumed by the CHK transition itself, so it never
  // needs to outlive that cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    buf_load   = 1'b0;
    buf_wr     = 1'b0;
    case (state_reg)
      IDLE:     if (req_valid) state_next = RD;
      RD:       state_next = CHK;
      CHK: begin
        buf_load   = 1'b1;
        state_next = out_dirty ? WB_CMD : FILL_CMD;
      end
      WB_CMD: if (mem.mem_cmd_ready) begin
        state_next = WB_DATA;
        cnt_next   = '0;
      end
      WB_DATA: if (mem.mem_wdata_ready) begin
        cnt_next = cnt_reg + 1'b1;   // wraps 7->0 as the burst ends
        if (cnt_reg == WORD_IDX_W'(WORDS_PER_LINE - 1)) state_next = FILL_CMD;
      end
      FILL_CMD: if (mem.mem_cmd_ready) begin
        state_next = FILL_DATA;
        cnt_next   = '0;
      end
      FILL_DATA: if (mem.mem_rdata_valid) begin
        buf_wr   = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == WORD_IDX_W'(WORDS_PER_LINE - 1)) state_next = COMMIT;
      end
      COMMIT:   state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  cache_line_buffer u_line_buffer (
    .clk       (main_clk),
    .rst_n     (main_rst_n),
    .load_en   (buf_load),
    .load_line (raw_out_full_data),
    .wr_en     (buf_wr),
    .wr_idx    (cnt_reg),
    .wr_data   (mem.mem_rdata),
    .rd_idx    (cnt_reg),
    .rd_data   (buf_rd_data),
    .line      (raw_in_full_data)
  );

  assign req_ready           = (state_reg == IDLE);
  assign done                = (state_reg == DONE);
  assign do_full_write       = (state_reg == COMMIT);
  assign target_segment      = seg_reg;
  assign target_way          = way_reg;
  assign mem.mem_cmd_valid   = (state_reg == WB_CMD) || (state_reg == FILL_CMD);
  assign mem.mem_cmd_write   = (state_reg == WB_CMD);
  assign mem.mem_cmd_addr    = (state_reg == WB_CMD) ? evict_reg : fill_reg;
  assign mem.mem_wdata       = buf_rd_data;
  assign mem.mem_wdata_valid = (state_reg == WB_DATA);

`ifdef CACHE_LINE_MOVER_FILL_FORWARD_EN
  logic                  fwd_valid_reg;
  logic [WORD_IDX_W-1:0] fwd_index_reg;
  logic [WORD_W-1:0]     fwd_word_reg;

  always_ff @(posedge main_clk) begin
    if (!main_rst_n) begin
      fwd_valid_reg <= 1'b0;
      fwd_index_reg <= '0;
      fwd_word_reg  <= '0;
    end else begin
      fwd_valid_reg <= buf_wr;
      if (buf_wr) begin
        fwd_index_reg <= cnt_reg;
        fwd_word_reg  <= mem.mem_rdata;
      end
    end
  end

  assign fwd_valid = fwd_valid_reg;
  assign fwd_index = fwd_index_reg;
  assign fwd_word  = fwd_word_reg;
`endif

endmodule

// File: tb/tb_cache_line_mover.sv
// Testbench for cache_line_mover: scoreboard-driven memory/array model.
// Expected commands, writeback words, committed lines (and forwarded words
// when CACHE_LINE_MOVER_FILL_FORWARD_EN is defined) are queued when the
// stimulus is set up or driven, and popped as the DUT produces them.
module tb_cache_line_mover;
  import cache_pkg::*;

  localparam int LINE_ADDR_W = 22;
  localparam int SEG_W       = 9;
  localparam int WAY_W       = 2;

  logic                   main_clk = 1'b0;
  logic                   main_rst_n = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [SEG_W-1:0]       req_segment = '0;
  logic [WAY_W-1:0]       req_way = '0;
  logic [LINE_ADDR_W-1:0] req_evict_addr = '0;
  logic [LINE_ADDR_W-1:0] req_fill_addr = '0;
  logic                   done;
  logic [SEG_W-1:0]       target_segment;
  logic [WAY_W-1:0]       target_way;
  logic                   do_full_write;
  logic [127:0]           raw_in_full_data;
  logic [127:0]           raw_out_full_data = '0;
  logic                   out_dirty = 1'b0;
`ifdef CACHE_LINE_MOVER_FILL_FORWARD_EN
  logic                   fwd_valid;
  logic [2:0]             fwd_index;
  logic [15:0]            fwd_word;
  logic [18:0]            fwd_q[$];
`endif

  always #5 main_clk = ~main_clk;

  cache_line_mover_if #(.LINE_ADDR_W(LINE_ADDR_W)) mem_bus ();

  cache_line_mover #(
    .LINE_ADDR_W(LINE_ADDR_W), .SEG_W(SEG_W), .WAY_W(WAY_W)
  ) dut (
    .main_clk          (main_clk),
    .main_rst_n        (main_rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_segment       (req_segment),
    .req_way           (req_way),
    .req_evict_addr    (req_evict_addr),
    .req_fill_addr     (req_fill_addr),
    .done              (done),
    .target_segment    (target_segment),
    .target_way        (target_way),
    .do_full_write     (do_full_write),
    .raw_in_full_data  (raw_in_full_data),
    .raw_out_full_data (raw_out_full_data),
    .out_dirty         (out_dirty),
    .mem               (mem_bus)
`ifdef CACHE_LINE_MOVER_FILL_FORWARD_EN
    ,
    .fwd_valid         (fwd_valid),
    .fwd_index         (fwd_index),
    .fwd_word          (fwd_word)
`endif
  );

  typedef struct packed {
    logic                   write;
    logic [LINE_ADDR_W-1:0] addr;
  } cmd_t;

  cmd_t         cmd_q[$];
  logic [15:0]  wdata_q[$];
  logic [127:0] commit_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  // stimulus configuration for the current request
  int           cfg_cmd_stall = 0;
  int           cfg_gap = 0;
  bit           cfg_wtoggle = 0;
  bit           cfg_junk = 0;
  logic [127:0] arr_line = '0;
  logic         arr_dirty = 1'b0;
  logic [8:0]   exp_seg = '0;
  logic [1:0]   exp_way = '0;
  logic [15:0]  fill_base = '0;

  // memory model state
  int stall_left = 0;
  int fill_idx = 0;
  int gap_left = 0;
  bit fill_active = 0;
  bit wphase = 0;
  int wb_count = 0;
  int fill_count = 0;
  int commit_count = 0;
  int done_count = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  bit prev_fw = 0;

  task automatic check_value(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    mem_bus.mem_cmd_ready   = 1'b0;
    mem_bus.mem_wdata_ready = 1'b0;
    mem_bus.mem_rdata       = '0;
    mem_bus.mem_rdata_valid = 1'b0;
  end

  // Memory controller + data array model and output monitor (negedge).
  always @(negedge main_clk) begin
    cyc++;
    if (!main_rst_n) begin
      cmd_q.delete();
      wdata_q.delete();
      commit_q.delete();
`ifdef CACHE_LINE_MOVER_FILL_FORWARD_EN
      fwd_q.delete();
`endif
      fill_active = 0;
      stall_left = cfg_cmd_stall;
      prev_fw = 0;
      mem_bus.mem_cmd_ready   = 1'b0;
      mem_bus.mem_wdata_ready = 1'b0;
      mem_bus.mem_rdata_valid = 1'b0;
    end else begin
      // array: target-addressed read data; wrong target gives inverted data
      if (target_segment == exp_seg && target_way == exp_way) begin
        raw_out_full_data = arr_line;
        out_dirty = arr_dirty;
      end else begin
        raw_out_full_data = ~arr_line;
        out_dirty = ~arr_dirty;
      end

      // fill word stream (runs before the command check so it starts the
      // cycle after the read command is accepted)
      if (fill_active) begin
        if (gap_left == 0) begin
          mem_bus.mem_rdata_valid = 1'b1;
          mem_bus.mem_rdata = fill_base + 16'(fill_idx);
`ifdef CACHE_LINE_MOVER_FILL_FORWARD_EN
          fwd_q.push_back({3'(fill_idx), fill_base + 16'(fill_idx)});
`endif
          fill_idx++;
          fill_count++;
          gap_left = cfg_gap;
          if (fill_idx == 8) fill_active = 0;
        end else begin
          mem_bus.mem_rdata_valid = 1'b0;
          mem_bus.mem_rdata = 16'(~fill_base);
          gap_left--;
        end
      end else begin
        mem_bus.mem_rdata_valid = cfg_junk ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_bus.mem_rdata = 16'($urandom);
      end

      // commands
      if (mem_bus.mem_cmd_valid) begin
        if (cmd_q.size() == 0) begin
          check_value("cmd_unexpected", 128'(1), 128'(0));
        end else begin
          check_value("cmd_write", 128'(mem_bus.mem_cmd_write), 128'(cmd_q[0].write));
          check_value("cmd_addr", 128'(mem_bus.mem_cmd_addr), 128'(cmd_q[0].addr));
          if (stall_left > 0) begin
            mem_bus.mem_cmd_ready = 1'b0;
            stall_left--;
          end else begin
            mem_bus.mem_cmd_ready = 1'b1;
            if (!cmd_q[0].write) begin
              fill_active = 1;
              fill_idx = 0;
              gap_left = 0;
            end
            void'(cmd_q.pop_front());
            stall_left = cfg_cmd_stall;
          end
        end
      end else begin
        mem_bus.mem_cmd_ready = 1'b0;
      end

      // writeback word stream; data must match the head word even while stalled
      if (mem_bus.mem_wdata_valid) begin
        if (wdata_q.size() == 0) begin
          check_value("wdata_unexpected", 128'(1), 128'(0));
          mem_bus.mem_wdata_ready = 1'b1;
        end else begin
          check_value("wdata_word", 128'(mem_bus.mem_wdata), 128'(wdata_q[0]));
          mem_bus.mem_wdata_ready = cfg_wtoggle ? wphase : 1'b1;
          wphase = ~wphase;
          if (mem_bus.mem_wdata_ready) begin
            void'(wdata_q.pop_front());
            wb_count++;
          end
        end
      end else begin
        mem_bus.mem_wdata_ready = 1'b0;
      end

      // full-line commit
      if (do_full_write) begin
        commit_count++;
        if (commit_q.size() == 0) begin
          check_value("commit_unexpected", 128'(1), 128'(0));
        end else begin
          check_value("commit_line", raw_in_full_data, commit_q.pop_front());
          check_value("commit_seg", 128'(target_segment), 128'(exp_seg));
          check_value("commit_way", 128'(target_way), 128'(exp_way));
          check_value("commit_after_8", 128'(fill_count), 128'(8));
        end
      end

      if (done) begin
        done_count++;
        done_cyc = cyc;
        check_value("done_after_commit", 128'(prev_fw), 128'(1));
      end
      prev_fw = do_full_write;

`ifdef CACHE_LINE_MOVER_FILL_FORWARD_EN
      if (fwd_valid) begin
        if (fwd_q.size() == 0) begin
          check_value("fwd_unexpected", 128'(1), 128'(0));
        end else begin
          check_value("fwd_index", 128'(fwd_index), 128'(fwd_q[0][18:16]));
          check_value("fwd_word", 128'(fwd_word), 128'(fwd_q[0][15:0]));
          void'(fwd_q.pop_front());
        end
      end
`endif

      if (req_valid && req_ready) acc_cyc = cyc;
    end
  end

  task automatic run_req(input logic [8:0] seg, input logic [1:0] way,
                         input logic [21:0] evict, input logic [21:0] fill,
                         input logic [15:0] base, input logic [127:0] line,
                         input logic dirty, input int cmd_stall,
                         input bit wtoggle, input int gap, input bit junk,
                         input bit hold_busy, input bit abort,
                         input bit chk_lat);
    logic [127:0] exp_line;
    int d0, c0;
    bit hit;
    cfg_cmd_stall = cmd_stall;
    cfg_wtoggle = wtoggle;
    cfg_gap = gap;
    cfg_junk = junk;
    arr_line = line;
    arr_dirty = dirty;
    exp_seg = seg;
    exp_way = way;
    fill_base = base;
    stall_left = cmd_stall;
    wphase = 0;
    wb_count = 0;
    fill_count = 0;
    if (dirty) begin
      cmd_q.push_back({1'b1, evict});
      for (int k = 0; k < 8; k++) wdata_q.push_back(line[16*k +: 16]);
    end
    cmd_q.push_back({1'b0, fill});
    for (int k = 0; k < 8; k++) exp_line[16*k +: 16] = base + 16'(k);
    commit_q.push_back(exp_line);
    d0 = done_count;
    c0 = commit_count;

    @(posedge main_clk);
    #2;
    check_value("req_ready_idle", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_segment = seg;
    req_way = way;
    req_evict_addr = evict;
    req_fill_addr = fill;
    @(posedge main_clk);
    #1;
    check_value("req_ready_busy", 128'(req_ready), 128'(0));
    if (hold_busy) begin
      req_segment = ~seg;
      req_way = ~way;
      req_evict_addr = ~evict;
      req_fill_addr = ~fill;
      repeat (3) @(posedge main_clk);
      #1;
    end
    req_valid = 1'b0;

    if (abort) begin
      hit = 0;
      for (int i = 0; i < 300; i++) begin
        @(posedge main_clk);
        if (wb_count >= 4) begin
          hit = 1;
          break;
        end
      end
      check_value("abort_reach_word3", 128'(hit), 128'(1));
      #2;
      main_rst_n = 1'b0;
      @(posedge main_clk);
      #1;
      check_value("abort_req_ready", 128'(req_ready), 128'(1));
      check_value("abort_cmd_valid", 128'(mem_bus.mem_cmd_valid), 128'(0));
      check_value("abort_wdata_valid", 128'(mem_bus.mem_wdata_valid), 128'(0));
      main_rst_n = 1'b1;
      repeat (20) @(posedge main_clk);
      #1;
      check_value("abort_no_commit", 128'(commit_count), 128'(c0));
      check_value("abort_no_done", 128'(done_count), 128'(d0));
      check_value("abort_idle", 128'(req_ready), 128'(1));
    end else begin
      hit = 0;
      for (int i = 0; i < 600; i++) begin
        @(posedge main_clk);
        if (done_count != d0) begin
          hit = 1;
          break;
        end
      end
      check_value("done_seen", 128'(hit), 128'(1));
      @(posedge main_clk);
      #1;
      check_value("ready_after_done", 128'(req_ready), 128'(1));
      check_value("done_single", 128'(done_count - d0), 128'(1));
      check_value("cmd_q_empty", 128'(cmd_q.size()), 128'(0));
      check_value("wdata_q_empty", 128'(wdata_q.size()), 128'(0));
      check_value("commit_q_empty", 128'(commit_q.size()), 128'(0));
      check_value("wb_words", 128'(wb_count), dirty ? 128'(8) : 128'(0));
      check_value("fill_words", 128'(fill_count), 128'(8));
`ifdef CACHE_LINE_MOVER_FILL_FORWARD_EN
      check_value("fwd_all_seen", 128'(fwd_q.size()), 128'(0));
`endif
      if (chk_lat) check_value("latency", 128'(done_cyc - acc_cyc), 128'(13));
    end
  endtask

  initial begin
    main_rst_n = 1'b0;
    repeat (3) @(posedge main_clk);
    #1;
    check_value("rst_req_ready", 128'(req_ready), 128'(1));
    check_value("rst_done", 128'(done), 128'(0));
    check_value("rst_full_write", 128'(do_full_write), 128'(0));
    check_value("rst_cmd_valid", 128'(mem_bus.mem_cmd_valid), 128'(0));
    check_value("rst_wdata_valid", 128'(mem_bus.mem_wdata_valid), 128'(0));
    check_value("rst_line", raw_in_full_data, 128'(0));
    check_value("rst_target", 128'({target_segment, target_way}), 128'(0));
    main_rst_n = 1'b1;

    // clean miss, zero-wait memory, latency check
    run_req(9'h155, 2'd2, 22'h01234, 22'h0ABCD, 16'h1000, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA,
            1'b0, 0, 0, 0, 0, 0, 0, 1);
    // dirty miss, junk fill strobes outside the fill burst, new request while busy
    run_req(9'h0AA, 2'd1, 22'h3FFFFF, 22'h00001, 16'h2000, 128'h0123456789ABCDEF0123456789ABCDEF,
            1'b1, 0, 0, 0, 1, 1, 0, 0);
    // backpressure: command stalled 5 cycles, wdata_ready toggling
    run_req(9'h1FF, 2'd3, 22'h12345, 22'h2AAAA, 16'h3000, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978,
            1'b1, 5, 1, 0, 0, 0, 0, 0);
    // gapped fill: one word every third cycle
    run_req(9'h001, 2'd0, 22'h00000, 22'h15555, 16'h4000, 128'h0,
            1'b0, 0, 0, 2, 1, 0, 0, 0);
    // reset during writeback after word 3
    run_req(9'h0F0, 2'd2, 22'h0BEEF, 22'h0CAFE, 16'h5000, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
            1'b1, 0, 0, 0, 0, 0, 1, 0);
    // normal request after the abort
    run_req(9'h123, 2'd1, 22'h0D00D, 22'h0F00F, 16'h6000, 128'h9999_8888_7777_6666_5555_4444_3333_2222,
            1'b1, 2, 1, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
